// File: rtl/i2c_periph_regfile.sv
`default_nettype none
// ============================================================================
// Module   : i2c_periph_regfile
// Brief    : Oversampled I2C target with an 8-bit register file, pointer
//            auto-increment and repeated-START support.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_periph_regfile #(
    parameter logic [6:0] DEV_ADDR = 7'h2A,
    parameter int         DEPTH    = 16,
    parameter logic [7:0] RST_VAL  = 8'h00,
    localparam int        PW       = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          scl_in,
    input  logic          sda_in,
    output logic          sda_oe,
    output logic          wr_strobe,
    output logic [PW-1:0] wr_index,
    output logic [7:0]    wr_data,
    output logic          busy
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_PTR      = 3'd3,
        ST_WDATA    = 3'd4,
        ST_RDATA    = 3'd5
    } state_t;

    state_t        r_state, w_state_nx;
    logic          r_scl_s1, r_scl_s2, r_scl_d;
    logic          r_sda_s1, r_sda_s2, r_sda_d;
    logic [3:0]    r_cnt, w_cnt_nx;
    logic [6:0]    r_shift, w_shift_nx;
    logic [7:0]    r_rd_shift, w_rd_shift_nx;
    logic [PW-1:0] r_ptr, w_ptr_nx;
    logic          r_oe, w_oe_nx;
    logic          r_busy, w_busy_nx;
    logic          r_rw, w_rw_nx;
    logic          r_strobe, w_strobe_nx;
    logic [PW-1:0] r_wr_index, w_wr_index_nx;
    logic [7:0]    r_wr_data, w_wr_data_nx;
    logic          w_reg_we;
    logic [7:0]    r_regs [DEPTH];

    logic          w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0]    w_byte;
    logic [PW-1:0] w_ptr_inc;

    // Synchronisers reset to the idle-bus level so no false event follows reset
    always_ff @(posedge clk) begin
        if (reset) begin
            {r_scl_s1, r_scl_s2, r_scl_d} <= 3'b111;
            {r_sda_s1, r_sda_s2, r_sda_d} <= 3'b111;
        end else begin
            {r_scl_s1, r_scl_s2, r_scl_d} <= {scl_in, r_scl_s1, r_scl_s2};
            {r_sda_s1, r_sda_s2, r_sda_d} <= {sda_in, r_sda_s1, r_sda_s2};
        end
    end

    assign w_scl_rise = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall = ~r_scl_s2 & r_scl_d;
    assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
    assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
    assign w_byte     = {r_shift, r_sda_s2};
    assign w_ptr_inc  = r_ptr + 1'b1;

    // r_cnt counts SCL rises in the current byte: 1..8 data, 9 acknowledge
    always_comb begin
        w_state_nx    = r_state;
        w_cnt_nx      = r_cnt;
        w_shift_nx    = r_shift;
        w_rd_shift_nx = r_rd_shift;
        w_ptr_nx      = r_ptr;
        w_oe_nx       = r_oe;
        w_busy_nx     = r_busy;
        w_rw_nx       = r_rw;
        w_strobe_nx   = 1'b0;
        w_wr_index_nx = r_wr_index;
        w_wr_data_nx  = r_wr_data;
        w_reg_we      = 1'b0;

        if (w_stop) begin
            w_state_nx = ST_IDLE;
            w_cnt_nx   = 4'd0;
            w_oe_nx    = 1'b0;
            w_busy_nx  = 1'b0;
        end else if (w_start) begin
            w_state_nx = ST_ADDR;
            w_cnt_nx   = 4'd0;
            w_oe_nx    = 1'b0;
            w_busy_nx  = 1'b0;
        end else if (r_state != ST_IDLE) begin
            if (w_scl_rise) begin
                if (r_cnt != 4'd9) w_cnt_nx = r_cnt + 4'd1;
                w_shift_nx = w_byte[6:0];
                if (r_cnt == 4'd7) begin
                    case (r_state)
                        ST_ADDR: begin
                            if (w_byte[7:1] == DEV_ADDR) begin
                                w_state_nx = ST_ADDR_ACK;
                                w_busy_nx  = 1'b1;
                                w_rw_nx    = w_byte[0];
                            end else begin
                                w_state_nx = ST_IDLE;
                            end
                        end
                        ST_PTR:   w_ptr_nx = w_byte[PW-1:0];
                        ST_WDATA: begin
                            w_reg_we      = 1'b1;
                            w_strobe_nx   = 1'b1;
                            w_wr_index_nx = r_ptr;
                            w_wr_data_nx  = w_byte;
                            w_ptr_nx      = w_ptr_inc;
                        end
                        default: ;
                    endcase
                end else if (r_cnt == 4'd8 && r_state == ST_RDATA) begin
                    w_ptr_nx = w_ptr_inc;
                    if (r_sda_s2) w_state_nx = ST_IDLE;
                    else          w_rd_shift_nx = r_regs[w_ptr_inc];
                end
            end else if (w_scl_fall) begin
                if (r_state == ST_RDATA) begin
                    if (r_cnt >= 4'd1 && r_cnt <= 4'd7) begin
                        w_oe_nx       = ~r_rd_shift[6];
                        w_rd_shift_nx = {r_rd_shift[6:0], 1'b0};
                    end else if (r_cnt == 4'd8) begin
                        w_oe_nx = 1'b0;
                    end else if (r_cnt == 4'd9) begin
                        w_oe_nx  = ~r_rd_shift[7];
                        w_cnt_nx = 4'd0;
                    end
                end else if (r_cnt == 4'd8) begin
                    w_oe_nx = 1'b1;
                end else if (r_cnt == 4'd9) begin
                    w_oe_nx  = 1'b0;
                    w_cnt_nx = 4'd0;
                    case (r_state)
                        ST_ADDR_ACK: begin
                            if (r_rw) begin
                                w_state_nx    = ST_RDATA;
                                w_rd_shift_nx = r_regs[r_ptr];
                                w_oe_nx       = ~r_regs[r_ptr][7];
                            end else begin
                                w_state_nx = ST_PTR;
                            end
                        end
                        ST_PTR:  w_state_nx = ST_WDATA;
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_shift    <= 7'd0;
            r_rd_shift <= 8'd0;
            r_ptr      <= '0;
            r_oe       <= 1'b0;
            r_busy     <= 1'b0;
            r_rw       <= 1'b0;
            r_strobe   <= 1'b0;
            r_wr_index <= '0;
            r_wr_data  <= 8'd0;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_shift    <= w_shift_nx;
            r_rd_shift <= w_rd_shift_nx;
            r_ptr      <= w_ptr_nx;
            r_oe       <= w_oe_nx;
            r_busy     <= w_busy_nx;
            r_rw       <= w_rw_nx;
            r_strobe   <= w_strobe_nx;
            r_wr_index <= w_wr_index_nx;
            r_wr_data  <= w_wr_data_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_regs[i] <= RST_VAL;
        end else if (w_reg_we) begin
            r_regs[r_ptr] <= w_byte;
        end
    end

    assign sda_oe    = r_oe;
    assign wr_strobe = r_strobe;
    assign wr_index  = r_wr_index;
    assign wr_data   = r_wr_data;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_i2c_periph_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_periph_regfile
// Brief    : Directed I2C master bench with a write-commit scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_periph_regfile;

    localparam int         Q  = 80;
    localparam logic [7:0] RV = 8'hC3;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_oe, wr_strobe, busy;
    logic [3:0] wr_index;
    logic [7:0] wr_data;
    wire        sda_line = sda_m & ~sda_oe;

    int         n_errors = 0;
    int         n_checks = 0;
    int         oe_cnt   = 0;
    int         busy_cnt = 0;
    int         str_cnt  = 0;
    logic [11:0] exp_q[$];

    always #5 clk = ~clk;

    i2c_periph_regfile #(
        .DEV_ADDR (7'h2A),
        .DEPTH    (16),
        .RST_VAL  (RV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (scl_m),
        .sda_in    (sda_line),
        .sda_oe    (sda_oe),
        .wr_strobe (wr_strobe),
        .wr_index  (wr_index),
        .wr_data   (wr_data),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Each committed write is matched against the oldest expected entry
    always @(negedge clk) begin
        if (sda_oe) oe_cnt++;
        if (busy)   busy_cnt++;
        if (wr_strobe) begin
            str_cnt++;
            check("strobe_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) check("strobe_idx_data", {wr_index, wr_data}, exp_q.pop_front());
        end
    end

    task automatic i2c_start();
        sda_m = 1'b1; #(Q);
        scl_m = 1'b1; #(Q);
        sda_m = 1'b0; #(Q);
        scl_m = 1'b0; #(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #(Q);
        scl_m = 1'b1; #(Q);
        sda_m = 1'b1; #(Q);
    endtask

    task automatic wbit(input logic b);
        sda_m = b; #(Q);
        scl_m = 1'b1; #(2*Q);
        scl_m = 1'b0; #(Q);
    endtask

    task automatic rbit(output logic b);
        sda_m = 1'b1; #(Q);
        scl_m = 1'b1; #(Q);
        b = sda_line; #(Q);
        scl_m = 1'b0; #(Q);
    endtask

    task automatic wbyte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) wbit(d[i]);
        rbit(ack);
    endtask

    task automatic rbyte(output logic [7:0] d, input logic master_ack);
        for (int i = 7; i >= 0; i--) rbit(d[i]);
        wbit(master_ack);
    endtask

    initial begin : stim
        logic [7:0] b;
        logic       a;
        int         s_oe, s_busy, s_str;

        repeat (4) @(posedge clk);
        #1;
        check("rst_sda_oe", sda_oe, 1'b0);
        check("rst_strobe", wr_strobe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_wr_index", wr_index, 4'd0);
        check("rst_wr_data", wr_data, 8'd0);
        @(negedge clk) reset = 1'b0;
        repeat (10) @(posedge clk);

        // Preload reg5 so the final pointer of the read test is visible
        i2c_start();
        wbyte(8'h54, a); check("pre_addr_ack", a, 1'b0);
        wbyte(8'h05, a);
        exp_q.push_back({4'd5, 8'h5A});
        wbyte(8'h5A, a); check("pre_data_ack", a, 1'b0);
        i2c_stop();

        // Single write
        i2c_start();
        wbyte(8'h54, a); check("t1_addr_ack", a, 1'b0);
        check("t1_busy_high", busy, 1'b1);
        wbyte(8'h03, a); check("t1_ptr_ack", a, 1'b0);
        exp_q.push_back({4'd3, 8'h67});
        wbyte(8'h67, a); check("t1_data_ack", a, 1'b0);
        i2c_stop();
        repeat (4) @(posedge clk);
        #1;
        check("t1_busy_low", busy, 1'b0);
        check("t1_strobe_count", str_cnt, 2);

        // Read with repeated START
        i2c_start();
        wbyte(8'h54, a);
        wbyte(8'h03, a);
        i2c_start();
        wbyte(8'h55, a); check("t2_addr_ack", a, 1'b0);
        rbyte(b, 1'b0);  check("t2_rd0", b, 8'h67);
        rbyte(b, 1'b1);  check("t2_rd1", b, RV);
        i2c_stop();
        i2c_start();
        wbyte(8'h55, a);
        rbyte(b, 1'b1);  check("t2_ptr_at_5", b, 8'h5A);
        i2c_stop();

        // Address miss
        s_oe = oe_cnt; s_busy = busy_cnt; s_str = str_cnt;
        i2c_start();
        wbyte(8'h56, a); check("t3_addr_nack", a, 1'b1);
        wbyte(8'h12, a); check("t3_data_nack", a, 1'b1);
        i2c_stop();
        check("t3_no_oe", oe_cnt, s_oe);
        check("t3_no_busy", busy_cnt, s_busy);
        check("t3_no_strobe", str_cnt, s_str);

        // Pointer wrap
        i2c_start();
        wbyte(8'h54, a);
        wbyte(8'h0F, a);
        exp_q.push_back({4'd15, 8'hA1});
        wbyte(8'hA1, a); check("t4_ack_a1", a, 1'b0);
        exp_q.push_back({4'd0, 8'hB2});
        wbyte(8'hB2, a); check("t4_ack_b2", a, 1'b0);
        i2c_stop();
        i2c_start();
        wbyte(8'h54, a);
        wbyte(8'h0F, a);
        i2c_start();
        wbyte(8'h55, a);
        rbyte(b, 1'b0); check("t4_reg15", b, 8'hA1);
        rbyte(b, 1'b1); check("t4_reg0", b, 8'hB2);
        i2c_stop();

        // STOP mid-byte
        s_str = str_cnt;
        i2c_start();
        wbyte(8'h54, a);
        wbyte(8'h07, a); check("t6_ptr_ack", a, 1'b0);
        wbit(1'b1); wbit(1'b0); wbit(1'b1); wbit(1'b1);
        i2c_stop();
        repeat (4) @(posedge clk);
        #1;
        check("t6_busy_low", busy, 1'b0);
        check("t6_no_strobe", str_cnt, s_str);
        i2c_start();
        wbyte(8'h54, a); check("t6_next_addr_ack", a, 1'b0);
        wbyte(8'h07, a);
        i2c_start();
        wbyte(8'h55, a);
        rbyte(b, 1'b1); check("t6_reg7_unchanged", b, RV);
        i2c_stop();

        // Reset while driving a 0 bit (reg3 = 0x67, MSB = 0)
        i2c_start();
        wbyte(8'h54, a);
        wbyte(8'h03, a);
        i2c_start();
        wbyte(8'h55, a); check("t5_addr_ack", a, 1'b0);
        check("t5_driving_low", sda_oe, 1'b1);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        check("t5_oe_released", sda_oe, 1'b0);
        check("t5_busy_cleared", busy, 1'b0);
        @(negedge clk) reset = 1'b0;
        repeat (4) @(posedge clk);
        i2c_stop();
        i2c_start();
        wbyte(8'h55, a); check("t5_post_addr_ack", a, 1'b0);
        rbyte(b, 1'b1);  check("t5_reg0_rst_val", b, RV);
        i2c_stop();

        repeat (4) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
